// File: rtl/serial_pkg.sv
// serial_pkg: shared types and defaults for the serial byte receiver.
// Build option: UART_PARITY_EN adds the PARITY state (8E1 framing).
package serial_pkg;

   localparam int DEFAULT_OVERSAMPLE = 16;
   localparam int DEFAULT_FIFO_DEPTH = 4;

   typedef enum logic [2:0] {
      ST_ARM    = 3'd0,
      ST_IDLE   = 3'd1,
      ST_START  = 3'd2,
      ST_DATA   = 3'd3,
`ifdef UART_PARITY_EN
      ST_PARITY = 3'd4,
`endif
      ST_STOP   = 3'd5
   } state_t;

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: small first-word-fall-through buffer for received bytes.
// A push while full is taken only when a pop frees the slot in the same cycle.
module byte_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic [7:0]    r_mem [DEPTH];

   logic w_do_push;
   logic w_do_pop;

   assign empty     = (r_count == '0);
   assign full      = (r_count == CNT_FULL);
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);
   assign dout      = empty ? 8'h00 : r_mem[r_rd_ptr];

   // pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // storage needs no reset; dout is masked while empty
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= din;
   end

endmodule

// File: rtl/serial_byte_rx.sv
// serial_byte_rx: oversampled 8N1 serial receiver feeding a byte buffer.
// Build option: UART_PARITY_EN switches framing to 8E1 (parity error
// reported on o_frame_err, byte discarded).
//
// state  | meaning
// ARM    | wait for rx high for one full bit time before listening
// IDLE   | line idle, waiting for a falling edge
// START  | counting to mid start bit, reject glitches
// DATA   | sampling 8 data bits, LSB first
// PARITY | sampling the even-parity bit (UART_PARITY_EN only)
// STOP   | sampling the stop bit, push byte or flag error
module serial_byte_rx
   import serial_pkg::*;
#(
   parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_frame_err,
   output logic       o_overrun,
   output logic       o_busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE/2 - 1);

   logic          r_rx_meta;
   logic          r_rx_sync;
   logic          r_rx_prev;
   state_t        r_state;
   state_t        w_state_nxt;
   logic [TW-1:0] r_tick;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_frame_err;
   logic          r_overrun;
`ifdef UART_PARITY_EN
   logic          r_par_err;
`endif

   logic w_fall;
   logic w_tick_last;
   logic w_tick_half;
   logic w_sample;
   logic w_stop_smp;
   logic w_push;
   logic w_frame_err;
   logic w_overrun;
   logic w_busy;
   logic w_empty;
   logic w_full;

   assign w_fall      = r_rx_prev && !r_rx_sync;
   assign w_tick_last = (r_tick == TICK_LAST);
   assign w_tick_half = (r_tick == TICK_HALF);

   // two-flop synchronizer plus one delayed copy for edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
      end
   end

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_ARM;
      else       r_state <= w_state_nxt;
   end

   // next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_ARM:   if (r_rx_sync && w_tick_last) w_state_nxt = ST_IDLE;
         ST_IDLE:  if (w_fall) w_state_nxt = ST_START;
         ST_START: if (w_tick_half) w_state_nxt = r_rx_sync ? ST_IDLE : ST_DATA;
         ST_DATA: begin
            if (w_tick_last && (r_bit == 3'd7)) begin
`ifdef UART_PARITY_EN
               w_state_nxt = ST_PARITY;
`else
               w_state_nxt = ST_STOP;
`endif
            end
         end
`ifdef UART_PARITY_EN
         ST_PARITY: if (w_tick_last) w_state_nxt = ST_STOP;
`endif
         ST_STOP:  if (w_tick_last) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_ARM;
      endcase
   end

   // per-state strobes: sample points, buffer push and error flags
   always_comb begin
      w_busy = (r_state != ST_ARM) && (r_state != ST_IDLE);
      w_sample = 1'b0;
      case (r_state)
         ST_START:  w_sample = w_tick_half;
         ST_DATA:   w_sample = w_tick_last;
`ifdef UART_PARITY_EN
         ST_PARITY: w_sample = w_tick_last;
`endif
         ST_STOP:   w_sample = w_tick_last;
         default:   w_sample = 1'b0;
      endcase
      w_stop_smp = (r_state == ST_STOP) && w_tick_last;
`ifdef UART_PARITY_EN
      w_push      = w_stop_smp && r_rx_sync && !r_par_err;
      w_frame_err = w_stop_smp && (!r_rx_sync || r_par_err);
`else
      w_push      = w_stop_smp && r_rx_sync;
      w_frame_err = w_stop_smp && !r_rx_sync;
`endif
      // full implies o_valid, so i_ready alone tells whether a pop frees a slot
      w_overrun = w_push && w_full && !i_ready;
   end

   // tick counter, bit counter and shift register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tick  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
`ifdef UART_PARITY_EN
         r_par_err <= 1'b0;
`endif
      end else begin
         if ((r_state == ST_IDLE) || w_sample ||
             ((r_state == ST_ARM) && (!r_rx_sync || w_tick_last)))
            r_tick <= '0;
         else
            r_tick <= r_tick + 1'b1;

         if (r_state == ST_START) begin
            r_bit <= '0;
`ifdef UART_PARITY_EN
            r_par_err <= 1'b0;
`endif
         end

         if ((r_state == ST_DATA) && w_sample) begin
            r_shift <= {r_rx_sync, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
         end

`ifdef UART_PARITY_EN
         if ((r_state == ST_PARITY) && w_sample)
            r_par_err <= (^r_shift) ^ r_rx_sync;
`endif
      end
   end

   // registered one-cycle error pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= w_frame_err;
         r_overrun   <= w_overrun;
      end
   end

   byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_push),
      .din   (r_shift),
      .pop   (i_ready),
      .dout  (o_data),
      .empty (w_empty),
      .full  (w_full)
   );

   assign o_valid     = !w_empty;
   assign o_frame_err = r_frame_err;
   assign o_overrun   = r_overrun;
   assign o_busy      = w_busy;

endmodule

// File: tb/tb_serial_byte_rx.sv
// tb_serial_byte_rx: scenario tasks for serial_byte_rx at 16 clk/bit, depth 4.
module tb_serial_byte_rx;

   localparam int OS    = 16;
   localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   // start edge reaches START three edges after it is driven (2 sync flops +
   // state register); mid start bit OS/2 later; stop mid-sample after the
   // remaining bits of the frame
   localparam int STOP_EDGE = 3 + OS/2 + (FRAME_BITS - 1) * OS;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic       i_ready = 1'b0;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_frame_err;
   logic       o_overrun;
   logic       o_busy;

   int checks = 0;
   int failures = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   int valid_cycles = 0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];

   serial_byte_rx #(
      .OVERSAMPLE (OS),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rx          (rx),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_frame_err (o_frame_err),
      .o_overrun   (o_overrun),
      .o_busy      (o_busy)
   );

   always #5 clk = ~clk;

   // observe consumer handshake and flag pulses away from the active edge
   always @(negedge clk) begin
      if (o_valid) valid_cycles++;
      if (o_valid && i_ready) got_q.push_back(o_data);
      if (o_frame_err) fe_cnt++;
      if (o_overrun) ov_cnt++;
   end

   task automatic align();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic v);
      rx = v;
      repeat (OS) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_v);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_PARITY_EN
      send_bit(^b);
`endif
      send_bit(stop_v);
   endtask

   task automatic test_reset();
      logic [7:0] e;
      reset = 1'b1;
      rx = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (o_data !== 8'h00)    begin failures++; $display("FAIL rst_in_data: got %02h want 00", o_data); end
      checks++; if (o_valid !== 1'b0)    begin failures++; $display("FAIL rst_in_valid: got %b want 0", o_valid); end
      checks++; if (o_frame_err !== 1'b0) begin failures++; $display("FAIL rst_in_ferr: got %b want 0", o_frame_err); end
      checks++; if (o_overrun !== 1'b0)  begin failures++; $display("FAIL rst_in_ovr: got %b want 0", o_overrun); end
      checks++; if (o_busy !== 1'b0)     begin failures++; $display("FAIL rst_in_busy: got %b want 0", o_busy); end
      align();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (o_data !== 8'h00)    begin failures++; $display("FAIL rst_out_data: got %02h want 00", o_data); end
      checks++; if (o_valid !== 1'b0)    begin failures++; $display("FAIL rst_out_valid: got %b want 0", o_valid); end
      checks++; if (o_frame_err !== 1'b0) begin failures++; $display("FAIL rst_out_ferr: got %b want 0", o_frame_err); end
      checks++; if (o_overrun !== 1'b0)  begin failures++; $display("FAIL rst_out_ovr: got %b want 0", o_overrun); end
      checks++; if (o_busy !== 1'b0)     begin failures++; $display("FAIL rst_out_busy: got %b want 0", o_busy); end
      repeat (OS + 4) @(posedge clk);
      e = 8'h00;
      checks++; if (got_q.size() != 0) begin failures++; $display("FAIL rst_no_bytes: got %0d bytes want %0d", got_q.size(), e); got_q.delete(); end
   endtask

   task automatic test_basic();
      int base_fe = fe_cnt;
      int base_ov = ov_cnt;
      int base_v  = valid_cycles;
      int lat = -1;
      logic [7:0] data_at = 8'h00;
      logic [7:0] e, g;
      i_ready = 1'b1;
      align();
      exp_q.push_back(8'hA5);
      fork
         send_frame(8'hA5, 1'b1);
         begin
            for (int k = 0; k < STOP_EDGE + 20; k++) begin
               @(negedge clk);
               if (o_valid && lat < 0) begin lat = k; data_at = o_data; end
            end
         end
      join
      checks++; if (lat != STOP_EDGE) begin failures++; $display("FAIL basic_latency: got %0d want %0d", lat, STOP_EDGE); end
      checks++; if (data_at !== 8'hA5) begin failures++; $display("FAIL basic_head: got %02h want a5", data_at); end
      checks++; if (valid_cycles - base_v != 1) begin failures++; $display("FAIL basic_valid_len: got %0d want 1", valid_cycles - base_v); end
      checks++; if (fe_cnt != base_fe) begin failures++; $display("FAIL basic_ferr: got %0d want %0d", fe_cnt, base_fe); end
      checks++; if (ov_cnt != base_ov) begin failures++; $display("FAIL basic_ovr: got %0d want %0d", ov_cnt, base_ov); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (got_q.size() == 0) begin failures++; $display("FAIL basic_data: got none want %02h", e); end
         else begin g = got_q.pop_front(); if (g !== e) begin failures++; $display("FAIL basic_data: got %02h want %02h", g, e); end end
      end
      checks++; if (got_q.size() != 0) begin failures++; $display("FAIL basic_extra: got %0d extra want 0", got_q.size()); got_q.delete(); end
   endtask

   task automatic test_glitch();
      int base_fe = fe_cnt;
      int base_v  = valid_cycles;
      i_ready = 1'b1;
      align();
      rx = 1'b0;
      repeat (6) @(posedge clk);
      #1 rx = 1'b1;
      @(negedge clk);
      checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_hi: got %b want 1", o_busy); end
      repeat (20) @(posedge clk);
      @(negedge clk);
      checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_lo: got %b want 0", o_busy); end
      checks++; if (valid_cycles != base_v) begin failures++; $display("FAIL glitch_valid: got %0d want %0d", valid_cycles, base_v); end
      checks++; if (fe_cnt != base_fe) begin failures++; $display("FAIL glitch_ferr: got %0d want %0d", fe_cnt, base_fe); end
      repeat (OS) @(posedge clk);
   endtask

   task automatic test_frame_err();
      int base_fe = fe_cnt;
      int base_v  = valid_cycles;
      logic [7:0] e, g;
      i_ready = 1'b1;
      align();
      send_frame(8'h3C, 1'b0);
      repeat (2) @(posedge clk);
      checks++; if (fe_cnt - base_fe != 1) begin failures++; $display("FAIL ferr_pulse: got %0d cycles want 1", fe_cnt - base_fe); end
      checks++; if (valid_cycles != base_v) begin failures++; $display("FAIL ferr_valid: got %0d want %0d", valid_cycles, base_v); end
      #1;
      send_bit(1'b1);
      exp_q.push_back(8'h55);
      send_frame(8'h55, 1'b1);
      repeat (8) @(posedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (got_q.size() == 0) begin failures++; $display("FAIL ferr_next: got none want %02h", e); end
         else begin g = got_q.pop_front(); if (g !== e) begin failures++; $display("FAIL ferr_next: got %02h want %02h", g, e); end end
      end
      checks++; if (got_q.size() != 0) begin failures++; $display("FAIL ferr_extra: got %0d extra want 0", got_q.size()); got_q.delete(); end
      checks++; if (fe_cnt - base_fe != 1) begin failures++; $display("FAIL ferr_next_flag: got %0d want 1", fe_cnt - base_fe); end
   endtask

   task automatic test_overrun();
      int base_fe = fe_cnt;
      int base_ov = ov_cnt;
      logic [7:0] e, g;
      i_ready = 1'b0;
      align();
      for (int b = 1; b <= 5; b++) begin
         if (b <= DEPTH) exp_q.push_back(8'(b));
         send_frame(8'(b), 1'b1);
      end
      repeat (4) @(posedge clk);
      @(negedge clk);
      checks++; if (ov_cnt - base_ov != 1) begin failures++; $display("FAIL ovr_pulse: got %0d want 1", ov_cnt - base_ov); end
      checks++; if (fe_cnt != base_fe) begin failures++; $display("FAIL ovr_ferr: got %0d want %0d", fe_cnt, base_fe); end
      checks++; if (o_valid !== 1'b1 || o_data !== 8'h01) begin failures++; $display("FAIL ovr_head: got v=%b d=%02h want v=1 d=01", o_valid, o_data); end
      align();
      i_ready = 1'b1;
      repeat (DEPTH + 4) @(posedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (got_q.size() == 0) begin failures++; $display("FAIL ovr_drain: got none want %02h", e); end
         else begin g = got_q.pop_front(); if (g !== e) begin failures++; $display("FAIL ovr_drain: got %02h want %02h", g, e); end end
      end
      checks++; if (got_q.size() != 0) begin failures++; $display("FAIL ovr_extra: got %0d extra want 0", got_q.size()); got_q.delete(); end
   endtask

   task automatic test_full_pop();
      int base_ov = ov_cnt;
      int base_fe = fe_cnt;
      logic [7:0] e, g;
      i_ready = 1'b0;
      align();
      for (int b = 1; b <= 5; b++) exp_q.push_back(8'(b));
      for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1);
      fork
         send_frame(8'h05, 1'b1);
         begin
            repeat (STOP_EDGE - 1) @(posedge clk);
            #1 i_ready = 1'b1;
            @(posedge clk);
            #1 i_ready = 1'b0;
         end
      join
      repeat (4) @(posedge clk);
      @(negedge clk);
      checks++; if (ov_cnt != base_ov) begin failures++; $display("FAIL fpop_ovr: got %0d want %0d", ov_cnt, base_ov); end
      checks++; if (fe_cnt != base_fe) begin failures++; $display("FAIL fpop_ferr: got %0d want %0d", fe_cnt, base_fe); end
      checks++; if (o_valid !== 1'b1 || o_data !== 8'h02) begin failures++; $display("FAIL fpop_head: got v=%b d=%02h want v=1 d=02", o_valid, o_data); end
      align();
      i_ready = 1'b1;
      repeat (DEPTH + 4) @(posedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (got_q.size() == 0) begin failures++; $display("FAIL fpop_drain: got none want %02h", e); end
         else begin g = got_q.pop_front(); if (g !== e) begin failures++; $display("FAIL fpop_drain: got %02h want %02h", g, e); end end
      end
      checks++; if (got_q.size() != 0) begin failures++; $display("FAIL fpop_extra: got %0d extra want 0", got_q.size()); got_q.delete(); end
   endtask

   task automatic test_back_to_back();
      int base_ov = ov_cnt;
      int base_fe = fe_cnt;
      logic [7:0] pat [3];
      logic [7:0] e, g;
      pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h6B;
      i_ready = 1'b1;
      align();
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(pat[i]);
         send_frame(pat[i], 1'b1);
      end
      repeat (8) @(posedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (got_q.size() == 0) begin failures++; $display("FAIL b2b_data: got none want %02h", e); end
         else begin g = got_q.pop_front(); if (g !== e) begin failures++; $display("FAIL b2b_data: got %02h want %02h", g, e); end end
      end
      checks++; if (got_q.size() != 0) begin failures++; $display("FAIL b2b_extra: got %0d extra want 0", got_q.size()); got_q.delete(); end
      checks++; if (ov_cnt != base_ov || fe_cnt != base_fe) begin failures++; $display("FAIL b2b_flags: got ov=%0d fe=%0d want ov=%0d fe=%0d", ov_cnt, fe_cnt, base_ov, base_fe); end
   endtask

   task automatic test_reset_midframe();
      int base_fe = fe_cnt;
      logic [7:0] e, g;
      i_ready = 1'b1;
      align();
      fork
         send_frame(8'h0F, 1'b1);
         begin
            repeat (70) @(posedge clk);
            @(negedge clk);
            checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL mrst_busy_pre: got %b want 1", o_busy); end
            #1 reset = 1'b1;
            @(negedge clk);
            checks++; if (o_busy !== 1'b0)     begin failures++; $display("FAIL mrst_busy: got %b want 0", o_busy); end
            checks++; if (o_valid !== 1'b0)    begin failures++; $display("FAIL mrst_valid: got %b want 0", o_valid); end
            checks++; if (o_data !== 8'h00)    begin failures++; $display("FAIL mrst_data: got %02h want 00", o_data); end
            checks++; if (o_frame_err !== 1'b0 || o_overrun !== 1'b0) begin failures++; $display("FAIL mrst_flags: got fe=%b ov=%b want 0 0", o_frame_err, o_overrun); end
            repeat (2) @(posedge clk);
            #1 reset = 1'b0;
         end
      join
      send_bit(1'b1);
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1);
      repeat (8) @(posedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (got_q.size() == 0) begin failures++; $display("FAIL mrst_next: got none want %02h", e); end
         else begin g = got_q.pop_front(); if (g !== e) begin failures++; $display("FAIL mrst_next: got %02h want %02h", g, e); end end
      end
      checks++; if (got_q.size() != 0) begin failures++; $display("FAIL mrst_extra: got %0d extra want 0", got_q.size()); got_q.delete(); end
      checks++; if (fe_cnt != base_fe) begin failures++; $display("FAIL mrst_ferr: got %0d want %0d", fe_cnt, base_fe); end
   endtask

`ifdef UART_PARITY_EN
   task automatic test_parity();
      int base_fe = fe_cnt;
      int base_v  = valid_cycles;
      logic [7:0] b;
      b = 8'h81;
      i_ready = 1'b1;
      align();
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(~(^b));
      send_bit(1'b1);
      repeat (4) @(posedge clk);
      checks++; if (fe_cnt - base_fe != 1) begin failures++; $display("FAIL par_ferr: got %0d want 1", fe_cnt - base_fe); end
      checks++; if (valid_cycles != base_v) begin failures++; $display("FAIL par_valid: got %0d want %0d", valid_cycles, base_v); end
      checks++; if (got_q.size() != 0) begin failures++; $display("FAIL par_extra: got %0d want 0", got_q.size()); got_q.delete(); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_full_pop();
      test_back_to_back();
      test_reset_midframe();
`ifdef UART_PARITY_EN
      test_parity();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
